// File: rtl/control_multicycle_if.sv
// control_multicycle_if: instruction/data memory request/ready handshake bundle
interface control_multicycle_if;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        imem_req;
  logic        dmem_ready;
  logic        dmem_req;
  logic        dmem_we;
  modport master(input imem_rdata, imem_ready, dmem_ready, output imem_req, dmem_req, dmem_we);
  modport slave(output imem_rdata, imem_ready, dmem_ready, input imem_req, dmem_req, dmem_we);
endinterface

// File: rtl/control_multicycle.sv
// control_multicycle: RV32I multi-cycle control FSM with IR, memory handshakes and traps
module control_multicycle #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  control_multicycle_if.master        mem,
  input  logic                        BrEq,
  input  logic                        BrLT,
  output logic                        PCWrite,
  output logic                        PCSel,
  output logic                        RegWEn,
  output logic [2:0]                  ImmSel,
  output logic                        ALUsrc1,
  output logic                        ALUsrc2,
  output logic [3:0]                  AluSEL,
  output logic                        BrUn,
  output logic [2:0]                  ldU,
  output logic [1:0]                  WBSel,
  output logic                        illegal,
  output logic                        timeout,
  output logic [2:0]                  state
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5} state_t;
  state_t state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic illegal_q, illegal_d, timeout_q, timeout_d;
  logic [6:0] op, f7;
  logic [2:0] f3, imm_sel;
  logic [3:0] alu_sel;
  logic is_r, is_i, is_lui, is_auipc, is_ld, is_st, is_br, is_jal, is_jalr, is_jmp;
  logic bad, taken, waiting, wd_hit, src1, src2, unused_ir;
  assign op        = ir_q[6:0];
  assign f3        = ir_q[14:12];
  assign f7        = ir_q[31:25];
  assign unused_ir = ^{ir_q[24:15], ir_q[11:7]};
  assign is_r      = op == 7'b0110011;
  assign is_i      = op == 7'b0010011;
  assign is_lui    = op == 7'b0110111;
  assign is_auipc  = op == 7'b0010111;
  assign is_ld     = op == 7'b0000011;
  assign is_st     = op == 7'b0100011;
  assign is_br     = op == 7'b1100011;
  assign is_jal    = op == 7'b1101111;
  assign is_jalr   = op == 7'b1100111;
  assign is_jmp    = is_jal | is_jalr;
  assign bad = !(is_r | is_i | is_lui | is_auipc | is_ld | is_st | is_br | is_jal | is_jalr)
             | (is_r && f7 != 7'h00 && f7 != 7'h20)
             | (is_i && f3 == 3'b001 && f7 != 7'h00)
             | (is_i && f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)
             | (is_br && f3[2:1] == 2'b01)
             | (is_ld && (f3 == 3'b011 || f3[2:1] == 2'b11))
             | (is_st && f3 >= 3'b011)
             | (is_jalr && f3 != 3'b000);
  assign taken = (f3 == 3'b000 && BrEq) | (f3 == 3'b001 && !BrEq)
               | ((f3 == 3'b100 || f3 == 3'b110) && BrLT) | ((f3 == 3'b101 || f3 == 3'b111) && !BrLT);
  assign imm_sel = is_st ? 3'b001 : is_br ? 3'b010 : (is_lui | is_auipc) ? 3'b011 : is_jal ? 3'b100 : 3'b000;
  assign alu_sel = is_r ? {ir_q[30], f3} : is_i ? {f3 == 3'b101 && ir_q[30], f3} : is_lui ? 4'hf : 4'h0;
  assign src1    = is_auipc | is_br | is_jal;
  assign src2    = !is_r;
  assign waiting = (state_q == FETCH && !mem.imem_ready) || (state_q == MEM && !mem.dmem_ready);
  assign wd_hit  = TIMEOUT_CYCLES != 0 && cnt_q == CNT_W'(TIMEOUT_CYCLES);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= FETCH;
      ir_q      <= 32'h0000_0013;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  // a ready in the same cycle as the watchdog hit takes priority over the trap
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    case (state_q)
      FETCH:
        if (mem.imem_ready) begin
          state_d = DECODE;
          ir_d    = mem.imem_rdata;
        end else if (wd_hit) begin
          state_d   = TRAP;
          timeout_d = 1'b1;
        end
      DECODE: begin
        state_d   = bad ? TRAP : EXEC;
        illegal_d = illegal_q | bad;
      end
      EXEC: state_d = (is_ld | is_st) ? MEM : (is_br | is_jmp) ? FETCH : WB;
      MEM:
        if (mem.dmem_ready) state_d = is_st ? FETCH : WB;
        else if (wd_hit) begin
          state_d   = TRAP;
          timeout_d = 1'b1;
        end
      WB: state_d = FETCH;
      default: state_d = TRAP;
    endcase
    cnt_d = (waiting && state_d == state_q) ? cnt_q + 1'b1 : '0;
  end
  always_comb begin
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    PCWrite      = 1'b0;
    PCSel        = 1'b0;
    RegWEn       = 1'b0;
    ImmSel       = 3'b000;
    ALUsrc1      = 1'b0;
    ALUsrc2      = 1'b0;
    AluSEL       = 4'h0;
    BrUn         = 1'b0;
    ldU          = 3'b000;
    WBSel        = 2'b00;
    if (!rst)
      case (state_q)
        FETCH: mem.imem_req = 1'b1;
        DECODE: ImmSel = imm_sel;
        EXEC: begin
          ImmSel  = imm_sel;
          ALUsrc1 = src1;
          ALUsrc2 = src2;
          AluSEL  = alu_sel;
          BrUn    = is_br & f3[1];
          PCSel   = is_br ? taken : is_jmp;
          PCWrite = is_br | is_jmp;
          RegWEn  = is_jmp;
          WBSel   = is_jmp ? 2'b10 : 2'b00;
        end
        MEM: begin
          ImmSel       = imm_sel;
          ALUsrc1      = src1;
          ALUsrc2      = src2;
          AluSEL       = alu_sel;
          mem.dmem_req = 1'b1;
          mem.dmem_we  = is_st;
          ldU          = f3;
          PCWrite      = is_st & mem.dmem_ready;
        end
        WB: begin
          ImmSel  = imm_sel;
          ALUsrc1 = src1;
          ALUsrc2 = src2;
          AluSEL  = alu_sel;
          ldU     = f3;
          RegWEn  = 1'b1;
          PCWrite = 1'b1;
          WBSel   = is_ld ? 2'b00 : 2'b01;
        end
        default: ;
      endcase
  end
  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign state   = state_q;
endmodule

// File: doc/control_multicycle.md
Name: control_multicycle

Overview:
- Multi-cycle RV32I control unit; next generation of the single-cycle combinational decoder.
- Sequences FETCH/DECODE/EXEC/MEM/WB over one shared datapath.
- Holds the instruction in an internal IR and handshakes with instruction and data memory.
- Traps on illegal encodings and on memory-handshake timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: maximum wait cycles for imem_ready or dmem_ready before a timeout trap; 0 disables the watchdog.
- CNT_W, 5: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_rdata  in  32  fetched instruction.
- imem_ready  in  1  imem_rdata valid this cycle.
- imem_req  out  1  fetch request.
- dmem_ready  in  1  data access complete this cycle.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store.
- BrEq, BrLT  in  1 each  branch comparator results, sampled in EXEC.
- PCWrite  out  1  update PC this cycle.
- PCSel  out  1  0 = PC+4, 1 = ALU result.
- RegWEn  out  1  register-file write enable.
- ImmSel  out  3  immediate format: I=000, S=001, B=010, U=011, J=100.
- ALUsrc1  out  1  0 = rs1, 1 = PC.
- ALUsrc2  out  1  0 = rs2, 1 = imm.
- AluSEL  out  4  ALU operation.
- BrUn  out  1  unsigned compare.
- ldU  out  3  load funct3 passed to load extender.
- WBSel  out  2  writeback source: 00 = mem, 01 = ALU, 10 = PC+4.
- illegal  out  1  sticky illegal-instruction flag.
- timeout  out  1  sticky watchdog flag.
- state  out  3  debug: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.

Behaviour:
- Reset (asynchronous):
  - state=FETCH, IR=32'h00000013, watchdog=0, illegal=timeout=0.
  - All outputs 0 while rst is high, including imem_req.
- Outputs are Moore: decoded from state and IR only. The exceptions are PCSel in EXEC for branches (uses BrEq/BrLT) and the handshake-qualified strobes noted below.
- FETCH:
  - imem_req=1.
  - On imem_ready: IR<=imem_rdata, go to DECODE.
- DECODE:
  - If IR is illegal: go to TRAP, set illegal.
  - Otherwise go to EXEC.
  - ImmSel is valid from DECODE onward.
- EXEC, by instruction class:
  - R-type: AluSEL={IR[30],funct3}, ALUsrc2=0, go to WB.
  - I-ALU: AluSEL={funct3==101 ? IR[30] : 0, funct3}, ALUsrc2=1, go to WB.
  - LUI: AluSEL=1111 (pass B), ALUsrc2=1, go to WB.
  - AUIPC: ALUsrc1=1, ALUsrc2=1, AluSEL=0000, go to WB.
  - Load/store: AluSEL=0000, ALUsrc2=1, go to MEM.
  - Branch:
    - ALUsrc1=1, ALUsrc2=1, ImmSel=010, BrUn=funct3[1].
    - taken = (000 & BrEq) | (001 & !BrEq) | ((100|110) & BrLT) | ((101|111) & !BrLT).
    - PCSel=taken, PCWrite=1, go to FETCH.
  - JAL: ALUsrc1=1, ImmSel=100, PCSel=1, PCWrite=1, RegWEn=1, WBSel=10, go to FETCH.
  - JALR: same as JAL except ALUsrc1=0 and ImmSel=000.
- MEM:
  - dmem_req=1; dmem_we=1 for stores; ldU=funct3.
  - Controls are held stable until dmem_ready.
  - On dmem_ready for a store: PCWrite=1, go to FETCH.
  - On dmem_ready for a load: go to WB.
- WB:
  - RegWEn=1, PCWrite=1 (PCSel=0), for exactly one cycle.
  - WBSel=00 for loads, 01 otherwise.
  - Go to FETCH.
- Illegal encodings:
  - IR[1:0]!=11, or unknown opcode.
  - R-type funct7 not 0000000/0100000.
  - I-ALU shift funct7 not 0000000/0100000 (0100000 only allowed with funct3=101).
  - Branch funct3 010/011.
  - Load funct3 011/110/111.
  - Store funct3 >= 011.
  - JALR funct3 != 000.
- Watchdog:
  - Increments each cycle a request is high with ready low.
  - Clears to 0 when ready arrives or state changes.
  - When the count equals TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0): go to TRAP and set timeout. A ready arriving in the same cycle wins (no trap).
- TRAP:
  - All strobes (PCWrite, RegWEn, imem_req, dmem_req) are 0.
  - Exit only via rst.
- Zero-wait latencies:
  - Branch/JAL/JALR: 3 cycles.
  - ALU/LUI/AUIPC and store: 4 cycles.
  - Load: 5 cycles.
- Reset asserted mid-MEM: dmem_req drops immediately (asynchronous), no PCWrite or RegWEn is issued.

Test Plan:
- add x3,x1,x2 (0x002081B3) with imem_ready immediate -> states 0,1,2,4,0; AluSEL=0000; RegWEn=1 and WBSel=01 in cycle 4 only.
- lw (0x0000A183), dmem_ready after 3 wait cycles -> MEM held 4 cycles with dmem_req=1 and dmem_we=0, then WB with WBSel=00; total 8 cycles.
- bne (0x00209463):
  - BrEq=0 -> PCSel=1, PCWrite=1 in EXEC.
  - BrEq=1 -> PCSel=0.
  - bltu -> BrUn=1.
- Illegal 0xFFFFFFFF -> TRAP after DECODE; illegal=1; no PCWrite; stays in TRAP until rst.
- imem_ready held low -> after 16 wait cycles state=5 and timeout=1. Repeat with ready in cycle 16 -> no trap.
- jal x1 (0x008000EF) -> EXEC asserts PCSel=1, RegWEn=1, WBSel=10, ImmSel=100; then FETCH.
